// File: rtl/serial_shift_right16.sv
// Iterative 16-bit right shifter/rotator: STEP bits per cycle, valid/ready in and out.
// Define SERIAL_SHIFT_RIGHT16_STICKY_EN to build the sticky (shifted-out OR) tracking.
module serial_shift_right16 #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             sticky,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] STEP_C = 4'(STEP);

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [3:0]       cnt_q;
    logic [1:0]       mode_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [3:0]       k;
    logic [WIDTH-1:0] shift_d;
    logic             unused_b;

    // Only the low nibble of the amount is meaningful.
    assign unused_b = ^b[WIDTH-1:4];

    assign k = (cnt_q < STEP_C) ? cnt_q : STEP_C;

    always_comb begin
        shift_d = sreg_q >> k;
        case (mode_q)
            2'b01:   shift_d = $unsigned($signed(sreg_q) >>> k);
            2'b10:   shift_d = WIDTH'({sreg_q, sreg_q} >> k);
            default: shift_d = sreg_q >> k;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sreg_q     <= a;
                        cnt_q      <= b[3:0];
                        mode_q     <= mode;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (b[3:0] == 4'd0) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    sreg_q <= shift_d;
                    cnt_q  <= cnt_q - k;
                    if (cnt_q == k) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Returning to IDLE costs a cycle, so no accept can overlap the release.
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_SHIFT_RIGHT16_STICKY_EN
    logic             sticky_q;
    logic [WIDTH-1:0] lost_mask;
    logic             lost;

    assign lost_mask = ~({WIDTH{1'b1}} << k);
    assign lost      = |(sreg_q & lost_mask);

    // Rotation loses no bits, so sticky only accumulates for the shift modes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (state_q == S_IDLE && in_valid) begin
            sticky_q <= 1'b0;
        end else if (state_q == S_SHIFT && mode_q != 2'b10 && lost) begin
            sticky_q <= 1'b1;
        end
    end

    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out       = sreg_q;

endmodule

// File: tb/tb_serial_shift_right16.sv
// Randomized bench for serial_shift_right16: four instances (STEP 1,2,4,8) share stimulus
// and are compared against an arithmetic reference of the shift/rotate/sticky rules.
module tb_serial_shift_right16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  mode;
    logic [3:0]  out_ready;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [3:0]  sticky;
    logic [3:0]  busy;
    logic [15:0] out_w [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_shift_right16 #(.WIDTH(16), .STEP(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .a         (a),
            .b         (b),
            .mode      (mode),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out       (out_w[g]),
            .sticky    (sticky[g]),
            .busy      (busy[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] x, input int n, input logic [1:0] m);
        int xu;
        int xs;
        xu = int'(x);
        xs = int'($signed(x));
        case (m)
            2'b01:   return 16'(xs >>> n);
            2'b10:   return 16'((xu >> n) | (xu << (16 - n)));
            default: return 16'(xu >> n);
        endcase
    endfunction

    function automatic logic ref_sticky(input logic [15:0] x, input int n, input logic [1:0] m);
`ifdef SERIAL_SHIFT_RIGHT16_STICKY_EN
        return (m != 2'b10) && ((int'(x) % (1 << n)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic randomize_ignored_inputs();
        in_valid = 1'($urandom_range(0, 1));
        a        = 16'($urandom);
        b        = 16'($urandom);
        mode     = 2'($urandom);
    endtask

    // Called at a negedge with every instance idle. The handshake cycle closes at the
    // capture edge; out_valid must then appear ceil(n/STEP) edges later.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [1:0] tm,
                          input int stall);
        int          n;
        int          lat [4];
        int          i;
        int          exp_lat;
        logic [15:0] eo;
        logic        es;
        n  = int'(tb_v[3:0]);
        eo = ref_shift(ta, n, tm);
        es = ref_sticky(ta, n, tm);
        check_eq("in_ready_idle", 32'(in_ready), 32'hF);
        a         = ta;
        b         = tb_v;
        mode      = tm;
        in_valid  = 1'b1;
        out_ready = 4'h0;
        @(negedge clk);
        check_eq("busy_after_accept", 32'(busy), 32'hF);
        check_eq("in_ready_after_accept", 32'(in_ready), 32'h0);
        for (int d = 0; d < 4; d++) lat[d] = -1;
        i = 0;
        while (i < 40) begin
            for (int d = 0; d < 4; d++) begin
                if (lat[d] < 0 && out_valid[d]) begin
                    lat[d]       = i;
                    out_ready[d] = 1'b0;
                end else if (lat[d] < 0) begin
                    out_ready[d] = 1'($urandom_range(0, 1));
                end
            end
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0 && lat[3] >= 0) break;
            randomize_ignored_inputs();
            @(negedge clk);
            i++;
        end
        for (int d = 0; d < 4; d++) begin
            exp_lat = (n + (1 << d) - 1) / (1 << d);
            check_eq($sformatf("latency step%0d a=%h b=%h m=%0d", 1 << d, ta, tb_v, tm),
                     32'(lat[d]), 32'(exp_lat));
            check_eq($sformatf("out step%0d a=%h b=%h m=%0d", 1 << d, ta, tb_v, tm),
                     32'(out_w[d]), 32'(eo));
            check_eq($sformatf("sticky step%0d a=%h b=%h m=%0d", 1 << d, ta, tb_v, tm),
                     32'(sticky[d]), 32'(es));
        end
        out_ready = 4'h0;
        for (int s = 0; s < stall; s++) begin
            randomize_ignored_inputs();
            @(negedge clk);
            check_eq("stall_out_valid", 32'(out_valid), 32'hF);
            check_eq("stall_in_ready", 32'(in_ready), 32'h0);
            for (int d = 0; d < 4; d++) begin
                check_eq($sformatf("stall_out step%0d", 1 << d), 32'(out_w[d]), 32'(eo));
                check_eq($sformatf("stall_sticky step%0d", 1 << d), 32'(sticky[d]), 32'(es));
            end
        end
        // Release with a competing operand present: it must not be taken this cycle.
        out_ready = 4'hF;
        in_valid  = 1'b1;
        a         = 16'($urandom);
        b         = 16'h0001;
        @(negedge clk);
        out_ready = 4'h0;
        in_valid  = 1'b0;
        check_eq("release_in_ready", 32'(in_ready), 32'hF);
        check_eq("release_out_valid", 32'(out_valid), 32'h0);
        check_eq("release_busy", 32'(busy), 32'h0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'hF);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check_eq({tag, "_busy"}, 32'(busy), 32'h0);
        check_eq({tag, "_sticky"}, 32'(sticky), 32'h0);
        for (int d = 0; d < 4; d++)
            check_eq($sformatf("%s_out step%0d", tag, 1 << d), 32'(out_w[d]), 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 16'hBEEF;
        b         = 16'h0003;
        mode      = 2'b00;
        out_ready = 4'hF;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'h0;
        check_reset_state("reset");

        run_op(16'h8001, 16'h0004, 2'b00, 0);
        run_op(16'h8000, 16'h000F, 2'b01, 0);
        run_op(16'h0001, 16'h0001, 2'b10, 0);
        run_op(16'h1234, 16'h0000, 2'b10, 0);
        run_op(16'hF000, 16'hFFF3, 2'b00, 0);
        run_op(16'hF000, 16'hFFF3, 2'b11, 0);
        run_op(16'hA5C3, 16'h0007, 2'b01, 10);

        // Reset landing on the third SHIFT cycle of a long arithmetic shift.
        a        = 16'hFFFF;
        b        = 16'h000F;
        mode     = 2'b01;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midop_reset");
        run_op(16'h0100, 16'h0008, 2'b00, 0);

        for (int t = 0; t < 80; t++) begin
            run_op(16'($urandom), 16'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
